// File: rtl/i2c_slave_recv_pkg.sv
// Shared types and constants for the I2C target write receiver.
// State encodings are 4-bit so the bench can compare against the same names.
package i2c_slave_recv_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  // Value of the R/W bit for a master write.
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_ADDR   = 4'd1,
    ACK_ADDR  = 4'd2,
    RX_REG    = 4'd3,
    ACK_REG   = 4'd4,
    RX_DATA   = 4'd5,
    ACK_DATA  = 4'd6,
    WAIT_STOP = 4'd7
  } stateT;

  function automatic logic isRxState(stateT s);
    return (s == RX_ADDR) || (s == RX_REG) || (s == RX_DATA);
  endfunction

  function automatic logic isAckState(stateT s);
    return (s == ACK_ADDR) || (s == ACK_REG) || (s == ACK_DATA);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings scl/sda into the clk domain and decodes bus events.
// Ports: clk/rst, raw sclIn/sdaIn; outputs sclRise, sclFall, startDet,
// stopDet (one-cycle flags) and sdaSync (synchronised sda level).
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclIn,
  input  logic sdaIn,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet,
  output logic sdaSync
);

  // [0],[1] = two-flop synchroniser, [2] = previous synced value for edges.
  logic [2:0] sclPipe;
  logic [2:0] sdaPipe;

  // Reset to the idle bus level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclPipe <= '1;
      sdaPipe <= '1;
    end else begin
      sclPipe <= {sclPipe[1:0], sclIn};
      sdaPipe <= {sdaPipe[1:0], sdaIn};
    end
  end

  assign sclRise  =  sclPipe[1] & ~sclPipe[2];
  assign sclFall  = ~sclPipe[1] &  sclPipe[2];
  // START/STOP require scl stable high across the sda transition.
  assign startDet =  sclPipe[1] &  sclPipe[2] & ~sdaPipe[1] &  sdaPipe[2];
  assign stopDet  =  sclPipe[1] &  sclPipe[2] &  sdaPipe[1] & ~sdaPipe[2];
  assign sdaSync  =  sdaPipe[1];

endmodule

// File: rtl/i2c_slave_recv.sv
// I2C target receiver for master write frames:
// START, {devAddr,W}, register address, data bytes..., STOP.
// Ports: clk, rst (sync, active-high), enable, scl, sda (open-drain),
// regAddr/regData/regWrite toward the register bank, busy, writeDone.
module i2c_slave_recv
  import i2c_slave_recv_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h3C,
  parameter int unsigned ACK_DELAY = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              scl,
  inout  wire               sda,
  output logic [BYTE_W-1:0] regAddr,
  output logic [BYTE_W-1:0] regData,
  output logic              regWrite,
  output logic              busy,
  output logic              writeDone
);

  localparam int unsigned DLY_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  logic sclRise, sclFall, startDet, stopDet, sdaSync;

  stateT             state, nextState;
  logic [CNT_W-1:0]  bitCnt, bitCntNext;
  logic [BYTE_W-1:0] shiftReg, shiftNext;
  logic [BYTE_W-1:0] regAddrNext, regDataNext;
  logic [DLY_W-1:0]  ackCnt, ackCntNext;
  logic              sdaLow, sdaLowNext;
  logic              ackPend, ackPendNext;
  logic              wroteAny, wroteAnyNext;
  logic              regWriteNext, busyNext, writeDoneNext;

  logic [BYTE_W-1:0] newByte;
  logic              byteDone, addrHit, ackRelease;

  i2c_bus_sync uSync (
    .clk     (clk),
    .rst     (rst),
    .sclIn   (scl),
    .sdaIn   (sda),
    .sclRise (sclRise),
    .sclFall (sclFall),
    .startDet(startDet),
    .stopDet (stopDet),
    .sdaSync (sdaSync)
  );

  // Open-drain: only ever pull low.
  assign sda = sdaLow ? 1'b0 : 1'bz;

  assign newByte    = {shiftReg[BYTE_W-2:0], sdaSync};
  assign byteDone   = isRxState(state) && sclRise && (bitCnt == CNT_W'(7));
  assign addrHit    = (newByte[7:1] == DEV_ADDR) && (newByte[0] == RW_WRITE);
  assign ackRelease = isAckState(state) && sdaLow && sclFall;

  // Register process: FSM state plus all datapath/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      ackCnt    <= '0;
      sdaLow    <= 1'b0;
      ackPend   <= 1'b0;
      wroteAny  <= 1'b0;
      regAddr   <= '0;
      regData   <= '0;
      regWrite  <= 1'b0;
      busy      <= 1'b0;
      writeDone <= 1'b0;
    end else begin
      state     <= nextState;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      ackCnt    <= ackCntNext;
      sdaLow    <= sdaLowNext;
      ackPend   <= ackPendNext;
      wroteAny  <= wroteAnyNext;
      regAddr   <= regAddrNext;
      regData   <= regDataNext;
      regWrite  <= regWriteNext;
      busy      <= busyNext;
      writeDone <= writeDoneNext;
    end
  end

  // Next state: disable beats STOP beats START beats scl-driven progress.
  always_comb begin
    nextState = state;
    if (!enable || stopDet) begin
      nextState = IDLE;
    end else if (startDet) begin
      nextState = RX_ADDR;
    end else begin
      unique case (state)
        RX_ADDR:  if (byteDone)   nextState = addrHit ? ACK_ADDR : WAIT_STOP;
        RX_REG:   if (byteDone)   nextState = ACK_REG;
        RX_DATA:  if (byteDone)   nextState = ACK_DATA;
        ACK_ADDR: if (ackRelease) nextState = RX_REG;
        ACK_REG,
        ACK_DATA: if (ackRelease) nextState = RX_DATA;
        default:  nextState = state;
      endcase
    end
  end

  // Next values for datapath and registered outputs.
  always_comb begin
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    ackCntNext    = ackCnt;
    sdaLowNext    = sdaLow;
    ackPendNext   = ackPend;
    wroteAnyNext  = wroteAny;
    regAddrNext   = regAddr;
    regDataNext   = regData;
    regWriteNext  = 1'b0;
    busyNext      = busy;
    writeDoneNext = 1'b0;

    if (!enable || stopDet || startDet) begin
      bitCntNext    = '0;
      sdaLowNext    = 1'b0;
      ackPendNext   = 1'b0;
      busyNext      = 1'b0;
      wroteAnyNext  = 1'b0;
      writeDoneNext = enable && stopDet && !startDet && wroteAny;
    end else begin
      if (isRxState(state) && sclRise && (bitCnt < CNT_W'(8))) begin
        shiftNext  = newByte;
        bitCntNext = bitCnt + CNT_W'(1);
      end

      if (byteDone) begin
        unique case (state)
          RX_ADDR: busyNext = addrHit;
          RX_REG:  regAddrNext = newByte;
          RX_DATA: begin
            regDataNext  = newByte;
            regWriteNext = 1'b1;
            wroteAnyNext = 1'b1;
          end
          default: ;
        endcase
      end

      // ACK: arm on the first scl fall, pull low after ACK_DELAY clocks,
      // release on the following scl fall.
      if (isAckState(state)) begin
        if (sdaLow) begin
          if (sclFall) begin
            sdaLowNext = 1'b0;
            bitCntNext = '0;
            if (state == ACK_DATA) regAddrNext = regAddr + BYTE_W'(1);
          end
        end else if (ackPend) begin
          if (ackCnt == DLY_W'(ACK_DELAY - 1)) begin
            sdaLowNext  = 1'b1;
            ackPendNext = 1'b0;
          end else begin
            ackCntNext = ackCnt + DLY_W'(1);
          end
        end else if (sclFall) begin
          ackPendNext = 1'b1;
          ackCntNext  = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_recv.sv
// Bench for i2c_slave_recv: bit-banged I2C master, frame-level reference model.
module tb_i2c_slave_recv;
  import i2c_slave_recv_pkg::*;

  localparam int unsigned Q = 12;            // clk cycles per quarter scl period
  localparam logic [6:0]  DEV = 7'h3C;

  logic clk = 1'b0;
  logic rst, enable, scl, masterLow;
  wire  sdaBus;
  logic [7:0] regAddr, regData;
  logic regWrite, busy, writeDone;

  assign sdaBus = masterLow ? 1'b0 : 1'bz;
  pullup (sdaBus);

  i2c_slave_recv #(.DEV_ADDR(DEV), .ACK_DELAY(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .scl      (scl),
    .sda      (sdaBus),
    .regAddr  (regAddr),
    .regData  (regData),
    .regWrite (regWrite),
    .busy     (busy),
    .writeDone(writeDone)
  );

  always #5 clk = ~clk;

  // Observed register-bank traffic.
  logic [15:0] wrQ[$];
  int doneCnt = 0;
  always @(negedge clk) begin
    if (regWrite)  wrQ.push_back({regAddr, regData});
    if (writeDone) doneCnt++;
  end

  int nCmp = 0;
  int nBad = 0;

  task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: register pointer, last data byte, expected writes.
  logic [7:0]  mAddr = 8'h00;
  logic [7:0]  mData = 8'h00;
  logic [15:0] expQ[$];
  int          wrIdx = 0;
  logic [7:0]  tx[$];

  task automatic clkWait(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busStart();
    masterLow = 1'b0; clkWait(Q);
    scl = 1'b1;       clkWait(Q);
    masterLow = 1'b1; clkWait(Q);
    scl = 1'b0;       clkWait(Q);
  endtask

  task automatic busStop();
    masterLow = 1'b1; clkWait(Q);
    scl = 1'b1;       clkWait(Q);
    masterLow = 1'b0; clkWait(Q);
  endtask

  task automatic sendBit(logic b);
    masterLow = ~b; clkWait(Q);
    scl = 1'b1;     clkWait(2 * Q);
    scl = 1'b0;     clkWait(Q);
  endtask

  task automatic sendByte(logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    masterLow = 1'b0; clkWait(Q);
    scl = 1'b1;       clkWait(Q);
    ack = (sdaBus === 1'b0);
    clkWait(Q);
    scl = 1'b0;       clkWait(Q);
  endtask

  // Sends tx[] (no START/STOP) and predicts ACKs and writes from frame rules.
  task automatic sendSegment(output logic addressed, output logic anyData);
    logic ack;
    addressed = (tx[0] == {DEV, 1'b0});
    anyData   = 1'b0;
    for (int i = 0; i < tx.size(); i++) begin
      sendByte(tx[i], ack);
      checkVal($sformatf("ack byte%0d=%02h", i, tx[i]), 32'(ack), 32'(addressed));
      if (addressed && i == 1) mAddr = tx[i];
      if (addressed && i >= 2) begin
        expQ.push_back({mAddr, tx[i]});
        mData   = tx[i];
        mAddr   = mAddr + 8'd1;
        anyData = 1'b1;
      end
    end
  endtask

  task automatic checkWrites(string tag);
    checkVal({tag, " nwrites"}, 32'(wrQ.size() - wrIdx), 32'(expQ.size()));
    foreach (expQ[k])
      if (wrIdx + k < wrQ.size()) checkVal({tag, " write"}, 32'(wrQ[wrIdx + k]), 32'(expQ[k]));
    wrIdx = wrQ.size();
    expQ.delete();
  endtask

  task automatic doFrame(string tag);
    logic addressed, anyData;
    int   d0;
    d0 = doneCnt;
    busStart();
    sendSegment(addressed, anyData);
    checkVal({tag, " busy"}, 32'(busy), 32'(addressed));
    if (!addressed) checkVal({tag, " wait state"}, 32'(dut.state), 32'(WAIT_STOP));
    busStop();
    checkVal({tag, " done"}, 32'(doneCnt - d0), (addressed && anyData) ? 32'd1 : 32'd0);
    checkVal({tag, " busy end"}, 32'(busy), 32'd0);
    checkVal({tag, " idle"}, 32'(dut.state), 32'(IDLE));
    checkVal({tag, " regAddr"}, 32'(regAddr), 32'(mAddr));
    checkVal({tag, " regData"}, 32'(regData), 32'(mData));
    checkWrites(tag);
  endtask

  // Aborts a frame with rst or enable=0 while the data-byte ACK is held.
  task automatic abortInAck(logic useRst, logic [7:0] reg8, logic [7:0] dat);
    logic a, d, ack;
    int   d0;
    string tag;
    tag = useRst ? "rstAbort" : "enAbort";
    d0 = doneCnt;
    tx.delete(); tx.push_back({DEV, 1'b0}); tx.push_back(reg8);
    busStart();
    sendSegment(a, d);
    for (int i = 7; i >= 0; i--) sendBit(dat[i]);
    expQ.push_back({mAddr, dat});
    mData = dat;
    masterLow = 1'b0; clkWait(Q);
    scl = 1'b1;       clkWait(Q);
    ack = (sdaBus === 1'b0);
    checkVal({tag, " ack held"}, 32'(ack), 32'd1);
    if (useRst) rst = 1'b1; else enable = 1'b0;
    clkWait(1);
    checkVal({tag, " sda released"}, 32'(sdaBus), 32'd1);
    checkVal({tag, " busy"}, 32'(busy), 32'd0);
    checkVal({tag, " regWrite"}, 32'(regWrite), 32'd0);
    checkVal({tag, " idle"}, 32'(dut.state), 32'(IDLE));
    if (useRst) begin
      mAddr = 8'h00;
      mData = 8'h00;
      rst = 1'b0;
    end
    checkVal({tag, " regAddr"}, 32'(regAddr), 32'(mAddr));
    checkVal({tag, " regData"}, 32'(regData), 32'(mData));
    clkWait(Q);
    scl = 1'b0; clkWait(Q);
    busStop();
    enable = 1'b1;
    clkWait(Q);
    checkVal({tag, " no done"}, 32'(doneCnt - d0), 32'd0);
    checkWrites(tag);
  endtask

  initial begin
    logic a, d;
    int   kind, nb;
    rst = 1'b1; enable = 1'b1; scl = 1'b1; masterLow = 1'b0;
    clkWait(4);
    rst = 1'b0;
    clkWait(2);
    checkVal("reset regAddr", 32'(regAddr), 32'h00);
    checkVal("reset regData", 32'(regData), 32'h00);
    checkVal("reset regWrite", 32'(regWrite), 32'd0);
    checkVal("reset busy", 32'(busy), 32'd0);
    checkVal("reset writeDone", 32'(writeDone), 32'd0);
    checkVal("reset state", 32'(dut.state), 32'(IDLE));
    checkVal("reset sda", 32'(sdaBus), 32'd1);

    tx.delete(); tx.push_back(8'h78); tx.push_back(8'h10); tx.push_back(8'hA5);
    doFrame("basic");

    tx.delete(); tx.push_back({7'h3D, 1'b0}); tx.push_back(8'h10); tx.push_back(8'h55);
    doFrame("wrongAddr");

    tx.delete(); tx.push_back({DEV, 1'b1}); tx.push_back(8'h10);
    doFrame("readReq");

    tx.delete(); tx.push_back(8'h78); tx.push_back(8'hFE);
    tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
    doFrame("burst");

    // Repeated START after the register byte: the aborted frame writes nothing.
    tx.delete(); tx.push_back(8'h78); tx.push_back(8'h30);
    busStart();
    sendSegment(a, d);
    tx.delete(); tx.push_back(8'h78); tx.push_back(8'h20); tx.push_back(8'h5A);
    doFrame("reStart");

    abortInAck(1'b1, 8'h40, 8'hC3);
    tx.delete(); tx.push_back(8'h78); tx.push_back(8'h41); tx.push_back(8'h99);
    doFrame("afterRst");

    abortInAck(1'b0, 8'h50, 8'h3E);
    tx.delete(); tx.push_back(8'h78); tx.push_back(8'h51); tx.push_back(8'h77);
    doFrame("afterEn");

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 9);
      tx.delete();
      if (kind < 7)       tx.push_back({DEV, 1'b0});
      else if (kind == 7) tx.push_back({DEV, 1'b1});
      else                tx.push_back(8'($urandom));
      nb = $urandom_range(0, 4);
      for (int j = 0; j < nb; j++) tx.push_back(8'($urandom));
      doFrame($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
